rf_writeback_queue: RTL and testbench
=====================================

Name: rf_writeback_queue

Overview:
- Write-side producer for the 32x32 two-read/one-write register file: collects destination-register results from the execute/memory pipeline and drives the file's single write port (PW, RW, LE).
- Buffers up to DEPTH pending writes in a FIFO and retires at most one per clock.
- Drops writes to R0, which is hardwired to zero.
- Reports read-after-write hazards on the file's two read addresses so the decode stage can stall.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, >=2).
- DW, 32, data width; matches PW.
- AW, 5, register address width; matches RA/RB/RW.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer presents a result.
- in_ready  out  1  queue can accept this cycle.
- in_rd  in  AW  destination register of the result.
- in_data  in  DW  result value.
- Flush  in  1  synchronous discard of all queued, not-yet-retired writes.
- Hold  in  1  suppress retirement this cycle; queue contents are kept.
- PW  out  DW  write data to the register file.
- RW  out  AW  write address to the register file.
- LE  out  1  write enable to the register file.
- RA  in  AW  read address A, as driven into the register file.
- RB  in  AW  read address B.
- hazard_a  out  1  a pending write targets RA.
- hazard_b  out  1  a pending write targets RB.
- count  out  clog2(DEPTH)+1  number of queued entries.

Behaviour:
- Reset, synchronous on a Clk edge with Rst=1:
  - count=0, read/write pointers=0, all entry valid bits=0.
  - LE=0, RW=0, PW=0.
  - in_ready=0 while Rst=1. in_ready=1 the cycle after Rst deasserts.
- Accept:
  - A push occurs when in_valid & in_ready at the edge.
  - in_ready = !Rst & (count<DEPTH). It is not raised by a same-cycle pop.
- R0 filter: a handshake with in_rd==0 completes (in_ready honoured) but nothing is enqueued and count is unchanged.
- Retire:
  - At an edge with count>0, Hold=0, Flush=0, the head entry is popped.
  - The popped entry is registered onto PW/RW with LE=1 for exactly the following cycle.
  - LE=0 in any cycle that did not follow a pop. PW/RW hold their last values when LE=0.
- Latency: a push at edge k has its earliest pop at edge k+1. LE=1 during cycle k+1..k+2, and the register file captures it at edge k+2. There is no same-edge push-to-pop bypass.
- Ordering: strict FIFO. Two writes to the same register retire in arrival order; the last one wins in the file.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full (count==DEPTH): in_ready=0. A pop at that edge frees one slot, so in_ready=1 next cycle.
- Empty: no pop, LE=0 next cycle. Hold on an empty queue has no effect.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided by count only.
- Flush:
  - Flush has priority over push and pop at the same edge.
  - All entries are invalidated and count=0; the incoming push is discarded.
  - LE=0 next cycle. A write already on LE in the current cycle still completes.
- Hold has priority over pop. Hold with Flush: Flush wins.
- Hazards (combinational):
  - hazard_a = (RA!=0) & (any valid queued entry has rd==RA, OR (LE & RW==RA)).
  - hazard_b is the same with RB.
  - An in-flight, not-yet-pushed input is not considered.
  - Hazards deassert in the cycle after the last matching write's LE cycle.
- Rst asserted mid-operation discards all queued writes. LE=0 from the next cycle, identical to the reset state.

Test Plan:
- Reset then single push (rd=5, data=0xDEADBEEF) at edge 1:
  - LE=1, RW=5, PW=0xDEADBEEF during cycle after edge 2; LE=0 afterwards.
  - Register file read with RA=5 returns 0xDEADBEEF after edge 3.
- Burst of 6 pushes (rd=1..6) with Hold=1:
  - in_ready drops after the 4th push, count=4.
  - On Hold=0, LE pulses 4 consecutive cycles with RW=1,2,3,4 in order.
  - Pushes 5 and 6 are accepted as slots free and retire after RW=4.
- Push rd=0 data=0x12345678: handshake completes, count stays 0, LE never asserts, reading R0 yields 0.
- Push rd=7 then rd=7 (data 0x1 then 0x2) with RA=7:
  - hazard_a=1 from the cycle after the first push until the cycle after the second LE pulse.
  - Final read of R7 = 0x2.
  - RB=0 keeps hazard_b=0 throughout.
- Queue holds 3 entries, Flush=1 coincident with push rd=9:
  - count=0 next cycle, in_ready=1, no further LE, hazard_a=0 for RA=9.
- Rst asserted with 2 entries queued and LE=1:
  - LE=0, RW=0, PW=0 next cycle, count=0.
  - in_ready=0 during Rst, 1 the cycle after release.

Source files
------------

// File: rtl/rf_writeback_queue_if.sv
// Bundle between the writeback queue and its neighbours: the producer-side
// push handshake and the register-file side (write port out, read addresses
// in, hazard flags back to decode).
//   in_valid/in_ready/in_rd/in_data : push handshake from execute/memory
//   PW/RW/LE                        : register-file write port
//   RA/RB                           : register-file read addresses
//   hazard_a/hazard_b               : pending-write match on RA/RB
// slave is the queue side; master is the environment side.
interface rf_writeback_queue_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic [DW-1:0] PW;
    logic [AW-1:0] RW;
    logic          LE;
    logic [AW-1:0] RA;
    logic [AW-1:0] RB;
    logic          hazard_a;
    logic          hazard_b;

    modport slave (
        input  in_valid, in_rd, in_data, RA, RB,
        output in_ready, PW, RW, LE, hazard_a, hazard_b
    );

    modport master (
        output in_valid, in_rd, in_data, RA, RB,
        input  in_ready, PW, RW, LE, hazard_a, hazard_b
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// Writeback queue feeding the single write port of the 32x32 register file.
// Buffers up to DEPTH results, retires at most one per clock onto PW/RW/LE
// (registered, LE high for exactly one cycle per retired entry), drops
// writes to R0, and flags read-after-write hazards on RA/RB.
//   Clk, Rst : clock, synchronous active-high reset
//   Flush    : discard all queued writes (beats push and pop)
//   Hold     : suppress retirement this cycle (beats pop)
//   bus      : push handshake, write port, read addresses, hazards
//   count    : number of queued entries
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Flush,
    input  logic                     Hold,
    rf_writeback_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int              PTRW = $clog2(DEPTH);
    localparam logic [PTRW:0]   FULL = (PTRW + 1)'(DEPTH);

    logic [AW-1:0]    ent_rd   [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW:0]    cnt;

    logic             le_q;
    logic [AW-1:0]    rw_q;
    logic [DW-1:0]    pw_q;

    logic             accept;
    logic             push;
    logic             pop;
    logic             haz_a;
    logic             haz_b;

    // Readiness looks only at the current occupancy; a pop in the same cycle
    // does not open a slot until the next cycle.
    assign bus.in_ready = !Rst && (cnt < FULL);
    assign accept       = bus.in_valid && bus.in_ready;
    // R0 writes complete the handshake but are never stored.
    assign push         = accept && (bus.in_rd != '0) && !Flush;
    assign pop          = (cnt != '0) && !Hold && !Flush;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ent_vld <= '0;
            le_q    <= 1'b0;
            rw_q    <= '0;
            pw_q    <= '0;
        end else if (Flush) begin
            // The write currently on LE has already been presented and
            // completes this edge; only queued entries are dropped.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ent_vld <= '0;
            le_q    <= 1'b0;
        end else begin
            le_q <= pop;
            if (pop) begin
                pw_q            <= ent_data[rd_ptr];
                rw_q            <= ent_rd[rd_ptr];
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTRW'(1);
            end
            // When both happen the queue is neither empty nor full, so the
            // two pointers address different slots.
            if (push) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PTRW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; validity is tracked by ent_vld.
    always_ff @(posedge Clk) begin
        if (push) begin
            ent_rd[wr_ptr]   <= bus.in_rd;
            ent_data[wr_ptr] <= bus.in_data;
        end
    end

    // A hazard covers both queued entries and the write on the port right
    // now, since the file only captures it at the end of the LE cycle.
    always_comb begin
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_rd[i] == bus.RA)) haz_a = 1'b1;
            if (ent_vld[i] && (ent_rd[i] == bus.RB)) haz_b = 1'b1;
        end
        if (le_q && (rw_q == bus.RA)) haz_a = 1'b1;
        if (le_q && (rw_q == bus.RB)) haz_b = 1'b1;
        if (bus.RA == '0) haz_a = 1'b0;
        if (bus.RB == '0) haz_b = 1'b0;
    end

    assign bus.hazard_a = haz_a;
    assign bus.hazard_b = haz_b;
    assign bus.LE       = le_q;
    assign bus.RW       = rw_q;
    assign bus.PW       = pw_q;
    assign count        = cnt;
endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;
    localparam int DEPTH = 4;

    logic       Clk;
    logic       Rst;
    logic       Flush;
    logic       Hold;
    logic [2:0] count;

    rf_writeback_queue_if #(.DW(32), .AW(5)) bus ();

    rf_writeback_queue #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Flush (Flush),
        .Hold  (Hold),
        .bus   (bus.slave),
        .count (count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file driven by the DUT's write port.
    logic [31:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    always @(posedge Clk) if (bus.LE) rf[bus.RW] <= bus.PW;

    // Reference model: an ordered list of pending writes plus the write port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_le;
    logic [4:0]  m_rw;
    logic [31:0] m_pw;
    logic [31:0] exp_rf [32];

    int checks = 0;
    int errors = 0;

    function automatic bit m_ready();
        return !Rst && (q.size() < DEPTH);
    endfunction

    function automatic bit exp_haz(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (m_le && m_rw == a) return 1'b1;
        foreach (q[i]) if (q[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare every output a little after the edge.
    task automatic step();
        bit   rdy;
        ent_t e;
        rdy = m_ready();
        @(posedge Clk);
        if (m_le) exp_rf[m_rw] = m_pw;
        if (Rst) begin
            q.delete();
            m_le = 1'b0;
            m_rw = '0;
            m_pw = '0;
        end else if (Flush) begin
            q.delete();
            m_le = 1'b0;
        end else begin
            if (q.size() > 0 && !Hold) begin
                e    = q.pop_front();
                m_le = 1'b1;
                m_rw = e.rd;
                m_pw = e.data;
            end else begin
                m_le = 1'b0;
            end
            if (bus.in_valid && rdy && bus.in_rd != 5'd0) begin
                e.rd   = bus.in_rd;
                e.data = bus.in_data;
                q.push_back(e);
            end
        end
        #1;
        chk("LE", 32'(bus.LE), 32'(m_le));
        chk("RW", 32'(bus.RW), 32'(m_rw));
        chk("PW", bus.PW, m_pw);
        chk("count", 32'(count), 32'(q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
        chk("hazard_a", 32'(bus.hazard_a), 32'(exp_haz(bus.RA)));
        chk("hazard_b", 32'(bus.hazard_b), 32'(exp_haz(bus.RB)));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        Flush        = 1'b0;
        Hold         = 1'b0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] data);
        bus.in_valid = 1'b1;
        bus.in_rd    = rd;
        bus.in_data  = data;
    endtask

    initial begin
        int         idx;
        int         cyc;
        logic [4:0] le_log[$];

        m_le = 1'b0;
        m_rw = '0;
        m_pw = '0;
        for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
        idle();
        Rst    = 1'b1;
        bus.RA = '0;
        bus.RB = '0;

        // Reset
        step();
        step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        Rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Single push rd=5
        push(5'd5, 32'hDEADBEEF);
        step();
        idle();
        step();
        chk("single_le", 32'(bus.LE), 32'd1);
        chk("single_rw", 32'(bus.RW), 32'd5);
        chk("single_pw", bus.PW, 32'hDEADBEEF);
        step();
        chk("single_le_off", 32'(bus.LE), 32'd0);
        chk("rf5", rf[5], 32'hDEADBEEF);

        // Burst of six under Hold
        Hold = 1'b1;
        idx  = 1;
        cyc  = 0;
        while (idx <= 6 && cyc < 40) begin
            bit hs;
            push(5'(idx), 32'h100 * idx);
            if (cyc == 6) Hold = 1'b0;
            hs = m_ready();
            step();
            if (bus.LE) le_log.push_back(bus.RW);
            if (hs) idx++;
            if (cyc == 3) begin
                chk("burst_full_count", 32'(count), 32'd4);
                chk("burst_full_ready", 32'(bus.in_ready), 32'd0);
            end
            cyc++;
        end
        chk("burst_all_accepted", 32'(idx), 32'd7);
        idle();
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.LE) le_log.push_back(bus.RW);
        end
        chk("burst_le_total", 32'(le_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < le_log.size()) chk("burst_order", 32'(le_log[i]), 32'(i + 1));

        // R0 write is dropped
        push(5'd0, 32'h12345678);
        step();
        chk("r0_count", 32'(count), 32'd0);
        idle();
        step();
        chk("r0_no_le", 32'(bus.LE), 32'd0);
        step();

        // Two writes to R7 with RA=7
        bus.RA = 5'd7;
        bus.RB = 5'd0;
        push(5'd7, 32'h1);
        step();
        chk("r7_haz_first", 32'(bus.hazard_a), 32'd1);
        push(5'd7, 32'h2);
        step();
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("r7_haz_clear", 32'(bus.hazard_a), 32'd0);
        chk("r7_final", rf[7], 32'h2);

        // Flush with three queued and a coincident push
        bus.RA = 5'd9;
        Hold   = 1'b1;
        push(5'd9, 32'h90);  step();
        push(5'd10, 32'hA0); step();
        push(5'd11, 32'hB0); step();
        chk("flush_pre_count", 32'(count), 32'd3);
        push(5'd9, 32'h99);
        Flush = 1'b1;
        step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_haz", 32'(bus.hazard_a), 32'd0);
        idle();
        for (int i = 0; i < 3; i++) step();

        // Reset mid-operation with two queued and LE high
        Hold = 1'b1;
        push(5'd12, 32'hC0); step();
        push(5'd13, 32'hD0); step();
        push(5'd14, 32'hE0); step();
        idle();
        step();
        chk("midrst_pre_le", 32'(bus.LE), 32'd1);
        chk("midrst_pre_count", 32'(count), 32'd2);
        Rst = 1'b1;
        step();
        chk("midrst_le", 32'(bus.LE), 32'd0);
        chk("midrst_rw", 32'(bus.RW), 32'd0);
        chk("midrst_pw", bus.PW, 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ready", 32'(bus.in_ready), 32'd0);
        Rst = 1'b0;
        step();
        chk("midrst_ready_rel", 32'(bus.in_ready), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            bus.in_valid = ($urandom_range(0, 99) < 65);
            bus.in_rd    = 5'($urandom_range(0, 7));
            bus.in_data  = $urandom;
            Hold         = ($urandom_range(0, 99) < 25);
            Flush        = ($urandom_range(0, 99) < 3);
            Rst          = ($urandom_range(0, 199) < 1);
            bus.RA       = 5'($urandom_range(0, 7));
            bus.RB       = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        Rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        for (int r = 0; r < 32; r++) chk("rf_final", rf[r], exp_rf[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
